// File: rtl/booth_pkg.sv
// Shared types and width helpers for the radix-4 Booth multiply-accumulate unit.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One recoded Booth digit: sign flag plus magnitude 0, 1 or 2.
  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } booth_digit_t;

  // Internal multiplier width: N plus one extension bit, rounded up to even.
  function automatic int calc_m(input int n);
    return 2 * ((n + 2) / 2);
  endfunction

  // Number of radix-4 iterations (two multiplier bits retired per cycle).
  function automatic int calc_k(input int n);
    return calc_m(n) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_mac_if.sv
// Command/result handshake bundle between a producer/consumer and the MAC.
interface booth_r4_mac_if #(
  parameter int N         = 18,
  parameter int ACC_GUARD = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N-1:0]               mcand;
  logic [N-1:0]               mplier;
  logic                       op_signed;
  logic                       op_acc;
  logic                       out_valid;
  logic                       out_ready;
  logic [2*N+ACC_GUARD-1:0]   result;

  modport master (
    output in_valid, mcand, mplier, op_signed, op_acc, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, mcand, mplier, op_signed, op_acc, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth recoder: triplet {p[1],p[0],p[-1]} to a signed
// addend of 0, +-1 or +-2 times the (already extended) multiplicand.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int M = 20
) (
  input  logic [2:0]   i_triplet,
  input  logic [M-1:0] i_mcand,
  output logic [M:0]   o_addend
);

  booth_digit_t w_digit;
  logic [M:0]   w_mag;

  // Decode the multiplier triplet into a Booth digit.
  always_comb begin
    w_digit.neg = 1'b0;
    w_digit.mag = 2'd0;
    case (i_triplet)
      3'b000, 3'b111: begin w_digit.neg = 1'b0; w_digit.mag = 2'd0; end
      3'b001, 3'b010: begin w_digit.neg = 1'b0; w_digit.mag = 2'd1; end
      3'b011:         begin w_digit.neg = 1'b0; w_digit.mag = 2'd2; end
      3'b100:         begin w_digit.neg = 1'b1; w_digit.mag = 2'd2; end
      3'b101, 3'b110: begin w_digit.neg = 1'b1; w_digit.mag = 2'd1; end
      default:        begin w_digit.neg = 1'b0; w_digit.mag = 2'd0; end
    endcase
  end

  // Scale the multiplicand by the digit magnitude (one guard bit) and apply sign.
  always_comb begin
    w_mag = '0;
    case (w_digit.mag)
      2'd1:    w_mag = {i_mcand[M-1], i_mcand};
      2'd2:    w_mag = {i_mcand, 1'b0};
      default: w_mag = '0;
    endcase
    if (w_digit.neg) begin
      o_addend = -w_mag;
    end else begin
      o_addend = w_mag;
    end
  end

endmodule

// File: rtl/booth_r4_mac.sv
// Sequential radix-4 Booth multiply-accumulate unit with valid/ready handshakes.
// One Booth iteration per cycle; the result and accumulator load on DONE entry.
module booth_r4_mac
  import booth_pkg::*;
#(
  parameter int N         = 18,
  parameter int ACC_GUARD = 8
) (
  input  logic          clk,
  input  logic          n_reset,
  booth_r4_mac_if.slave mac
);

  localparam int M  = calc_m(N);
  localparam int K  = calc_k(N);
  localparam int W  = 2 * N + ACC_GUARD;
  localparam int CW = $clog2(K + 1);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_result;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [M-1:0]    r_mcand;
  logic [M-1:0]    r_lower;
  logic [M:0]      r_upper;
  logic            r_pm1;
  logic            r_signed;
  logic            r_op_acc;

  logic            w_accept;
  logic            w_last;
  logic [M-1:0]    w_mcand_ext;
  logic [M-1:0]    w_mplier_ext;
  logic [M:0]      w_addend;
  logic [M:0]      w_upper_sum;
  logic [M:0]      w_upper_next;
  logic [M-1:0]    w_lower_next;
  logic [2*N-1:0]  w_prod_2n;
  logic [W-1:0]    w_prod_ext;
  logic [W-1:0]    w_result_next;

  booth_r4_digit #(.M(M)) u_digit (
    .i_triplet ({r_lower[1:0], r_pm1}),
    .i_mcand   (r_mcand),
    .o_addend  (w_addend)
  );

  // Operand extension at accept, one Booth step, and product/result formation.
  always_comb begin
    w_mcand_ext   = {{(M-N){mac.op_signed & mac.mcand[N-1]}}, mac.mcand};
    w_mplier_ext  = {{(M-N){mac.op_signed & mac.mplier[N-1]}}, mac.mplier};
    w_upper_sum   = r_upper + w_addend;
    w_upper_next  = {{2{w_upper_sum[M]}}, w_upper_sum[M:2]};
    w_lower_next  = {w_upper_sum[1:0], r_lower[M-1:2]};
    w_prod_2n     = (2*N)'({w_upper_next, w_lower_next});
    if (r_signed) begin
      w_prod_ext = W'($signed(w_prod_2n));
    end else begin
      w_prod_ext = W'(w_prod_2n);
    end
    if (r_op_acc) begin
      w_result_next = r_acc + w_prod_ext;
    end else begin
      w_result_next = w_prod_ext;
    end
  end

  // Next-state logic: accept in IDLE, K iterations in BUSY, hold in DONE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mac.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_BUSY;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt == CW'(K - 1)) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (mac.out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: operand latch, partial-product shifting, counter, result/accumulator.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_lower     <= '0;
      r_upper     <= '0;
      r_pm1       <= 1'b0;
      r_signed    <= 1'b0;
      r_op_acc    <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == ST_IDLE);
      r_out_valid <= (w_state_next == ST_DONE);
      if (w_accept) begin
        r_mcand  <= w_mcand_ext;
        r_lower  <= w_mplier_ext;
        r_upper  <= '0;
        r_pm1    <= 1'b0;
        r_cnt    <= '0;
        r_signed <= mac.op_signed;
        r_op_acc <= mac.op_acc;
      end else if (r_state == ST_BUSY) begin
        r_upper <= w_upper_next;
        r_lower <= w_lower_next;
        r_pm1   <= r_lower[1];
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_last) begin
        r_result <= w_result_next;
        r_acc    <= w_result_next;
      end
    end
  end

  assign mac.in_ready  = r_in_ready;
  assign mac.out_valid = r_out_valid;
  assign mac.result    = r_result;

endmodule

// File: tb/tb_booth_r4_mac.sv
// Self-checking bench for booth_r4_mac: three instances (N=8, 5, 18) driven
// from one directed/randomized sequence and compared to an arithmetic model.
module tb_booth_r4_mac;

  logic clk;
  logic n_reset;

  booth_r4_mac_if #(.N(8),  .ACC_GUARD(8)) if8  ();
  booth_r4_mac_if #(.N(5),  .ACC_GUARD(8)) if5  ();
  booth_r4_mac_if #(.N(18), .ACC_GUARD(8)) if18 ();

  booth_r4_mac #(.N(8),  .ACC_GUARD(8)) u_dut8  (.clk(clk), .n_reset(n_reset), .mac(if8));
  booth_r4_mac #(.N(5),  .ACC_GUARD(8)) u_dut5  (.clk(clk), .n_reset(n_reset), .mac(if5));
  booth_r4_mac #(.N(18), .ACC_GUARD(8)) u_dut18 (.clk(clk), .n_reset(n_reset), .mac(if18));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance constants: operand width, latency K, result width.
  int N_OF [3] = '{8, 5, 18};
  int K_OF [3] = '{5, 3, 10};
  int W_OF [3] = '{24, 18, 44};

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [63:0] accm     [3];
  logic [63:0] pend_exp [3];

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input logic [63:0] v, input int n);
    longint t;
    t = longint'(v << (64 - n));
    return t >>> (64 - n);
  endfunction

  // Exact mathematical product of two n-bit operands in the given mode.
  function automatic logic [63:0] ref_prod(input int n, input logic [63:0] a,
                                           input logic [63:0] b, input bit s);
    longint x;
    longint y;
    x = s ? sext(a, n) : longint'(a & mask(n));
    y = s ? sext(b, n) : longint'(b & mask(n));
    return 64'(x * y);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [63:0] a,
                       input logic [63:0] b, input logic s, input logic acc);
    case (sel)
      0: begin if8.in_valid = v;  if8.mcand = a[7:0];   if8.mplier = b[7:0];   if8.op_signed = s;  if8.op_acc = acc;  end
      1: begin if5.in_valid = v;  if5.mcand = a[4:0];   if5.mplier = b[4:0];   if5.op_signed = s;  if5.op_acc = acc;  end
      default: begin if18.in_valid = v; if18.mcand = a[17:0]; if18.mplier = b[17:0]; if18.op_signed = s; if18.op_acc = acc; end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic v);
    case (sel)
      0: if8.out_ready = v;
      1: if5.out_ready = v;
      default: if18.out_ready = v;
    endcase
  endtask

  function automatic logic get_in_ready(input int sel);
    case (sel)
      0: return if8.in_ready;
      1: return if5.in_ready;
      default: return if18.in_ready;
    endcase
  endfunction

  function automatic logic get_in_valid(input int sel);
    case (sel)
      0: return if8.in_valid;
      1: return if5.in_valid;
      default: return if18.in_valid;
    endcase
  endfunction

  function automatic logic get_out_valid(input int sel);
    case (sel)
      0: return if8.out_valid;
      1: return if5.out_valid;
      default: return if18.out_valid;
    endcase
  endfunction

  function automatic logic [63:0] get_result(input int sel);
    case (sel)
      0: return 64'(if8.result);
      1: return 64'(if5.result);
      default: return 64'(if18.result);
    endcase
  endfunction

  // Deassert the request and scramble the operand pins after acceptance.
  task automatic drop(input int sel);
    drive(sel, 1'b0, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
  endtask

  // Present a request and record the value the model expects for it.
  task automatic send(input int sel, input logic [63:0] a, input logic [63:0] b,
                      input bit s, input bit acc);
    logic [63:0] p;
    p = ref_prod(N_OF[sel], a, b, s);
    pend_exp[sel] = (acc ? accm[sel] + p : p) & mask(W_OF[sel]);
    drive(sel, 1'b1, a, b, s, acc);
  endtask

  // Count edges until out_valid, releasing in_valid once it has been accepted.
  task automatic wait_result(input int sel, input int exp_edges, input string tag);
    int  e;
    bit  got;
    logic rdy_before;
    e = 0;
    got = 1'b0;
    rdy_before = get_in_ready(sel);
    while (!got && e < 60) begin
      @(posedge clk);
      #1;
      e++;
      if (rdy_before && get_in_valid(sel)) drop(sel);
      rdy_before = get_in_ready(sel);
      if (get_out_valid(sel)) got = 1'b1;
    end
    chk({tag, "_lat"}, 64'(e), 64'(exp_edges));
    chk({tag, "_res"}, get_result(sel), pend_exp[sel]);
    accm[sel] = pend_exp[sel];
  endtask

  task automatic op(input int sel, input logic [63:0] a, input logic [63:0] b,
                    input bit s, input bit acc, input string tag);
    send(sel, a, b, s, acc);
    wait_result(sel, K_OF[sel] + 1, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] held;
    int          seen;
    n_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      set_ready(i, 1'b1);
      accm[i] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready",  64'(get_in_ready(i)),  64'd1);
      chk("rst_out_valid", 64'(get_out_valid(i)), 64'd0);
      chk("rst_result",    get_result(i),         64'd0);
    end

    // Directed N=8 cases with hard-coded expected values.
    op(0, 64'd3, 64'hFB, 1'b1, 1'b0, "s3xm5");
    chk("s3xm5_const", get_result(0), 64'hFFFFF1);
    op(0, 64'h80, 64'h80, 1'b1, 1'b0, "sminxmin");
    chk("sminxmin_const", get_result(0), 64'd16384);
    op(0, 64'hFF, 64'hFF, 1'b0, 1'b0, "umaxxmax");
    chk("umaxxmax_const", get_result(0), 64'd65025);
    op(0, 64'h80, 64'h7F, 1'b1, 1'b0, "sminxmax");
    chk("sminxmax_const", get_result(0), 64'hFFC080);
    op(0, 64'h80, 64'h00, 1'b1, 1'b0, "x_zero_s");
    chk("x_zero_s_const", get_result(0), 64'd0);
    op(0, 64'h00, 64'hFF, 1'b0, 1'b0, "zero_x_u");
    chk("zero_x_u_const", get_result(0), 64'd0);

    // Accumulate chain.
    op(0, 64'd10, 64'd10, 1'b0, 1'b0, "acc1");
    chk("acc1_const", get_result(0), 64'd100);
    op(0, 64'd20, 64'd20, 1'b0, 1'b1, "acc2");
    chk("acc2_const", get_result(0), 64'd500);
    op(0, 64'hE2, 64'd30, 1'b1, 1'b1, "acc3");
    chk("acc3_const", get_result(0), 64'hFFFE70);

    // Backpressure: hold out_ready low, pending request must wait.
    set_ready(0, 1'b0);
    send(0, 64'd7, 64'd9, 1'b0, 1'b0);
    wait_result(0, K_OF[0] + 1, "bp");
    held = get_result(0);
    send(0, 64'd11, 64'hF3, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(get_out_valid(0)), 64'd1);
      chk("bp_result",    get_result(0),         held);
      chk("bp_in_ready",  64'(get_in_ready(0)),  64'd0);
    end
    set_ready(0, 1'b1);
    wait_result(0, K_OF[0] + 2, "bp_next");
    chk("bp_next_const", get_result(0), 64'hFFFF71);
    @(posedge clk);
    #1;

    // Reset during the third iteration discards the operation.
    send(0, 64'd100, 64'd100, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drop(0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_reset = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) accm[i] = 64'd0;
    chk("mid_rst_in_ready",  64'(get_in_ready(0)),  64'd1);
    chk("mid_rst_out_valid", 64'(get_out_valid(0)), 64'd0);
    chk("mid_rst_result",    get_result(0),         64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (get_out_valid(0)) seen++;
    end
    chk("mid_rst_no_valid", 64'(seen), 64'd0);
    op(0, 64'd2, 64'd3, 1'b0, 1'b1, "post_rst");
    chk("post_rst_const", get_result(0), 64'd6);

    // Boundaries for the other widths.
    op(1, 64'h10, 64'h10, 1'b1, 1'b0, "n5_sminxmin");
    op(1, 64'h1F, 64'h1F, 1'b0, 1'b0, "n5_umaxxmax");
    op(2, 64'h20000, 64'h20000, 1'b1, 1'b0, "n18_sminxmin");
    op(2, 64'h3FFFF, 64'h3FFFF, 1'b0, 1'b0, "n18_umaxxmax");

    // Random sweeps against the model.
    for (int sel = 0; sel < 3; sel++) begin
      for (int t = 0; t < ((sel == 0) ? 200 : 1000); t++) begin
        op(sel, 64'($urandom) & mask(N_OF[sel]), 64'($urandom) & mask(N_OF[sel]),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
